// File: rtl/seq_chunk_comparator.sv
// Multi-cycle MSB-first chunked magnitude comparator with l/e/g cascade inputs.
// Optional SEQ_CMP_SIGNED_EN adds a sgn input for two's-complement ordering.
module seq_chunk_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             l,
  input  logic             e,
  input  logic             g,
`ifdef SEQ_CMP_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             et,
  output logic             gt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             l_q;
  logic             e_q;
  logic             g_q;
  logic             busy_q;
  logic             done_q;
  logic             lt_q;
  logic             et_q;
  logic             gt_q;
`ifdef SEQ_CMP_SIGNED_EN
  logic             sgn_q;
`endif

  logic [WIDTH-1:0] a_x;
  logic [WIDTH-1:0] b_x;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;

  // Flipping both MSBs maps two's-complement order onto unsigned order;
  // only the top chunk ever sees the flipped bit.
  always_comb begin
    a_x = a_q;
    b_x = b_q;
`ifdef SEQ_CMP_SIGNED_EN
    if (sgn_q) begin
      a_x[WIDTH-1] = ~a_q[WIDTH-1];
      b_x[WIDTH-1] = ~b_q[WIDTH-1];
    end
`endif
    ca = CHUNK'(a_x >> (int'(idx_q) * CHUNK));
    cb = CHUNK'(b_x >> (int'(idx_q) * CHUNK));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      et_q    <= 1'b0;
      gt_q    <= 1'b0;
`ifdef SEQ_CMP_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            l_q     <= l;
            e_q     <= e;
            g_q     <= g;
`ifdef SEQ_CMP_SIGNED_EN
            sgn_q   <= sgn;
`endif
            idx_q   <= IW'(NCHUNK - 1);
            busy_q  <= 1'b1;
            state_q <= CMP;
          end
        end
        CMP: begin
          if (ca != cb) begin
            lt_q    <= (ca < cb);
            gt_q    <= (ca > cb);
            et_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (idx_q == '0) begin
            lt_q    <= l_q;
            et_q    <= e_q;
            gt_q    <= g_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = lt_q;
  assign et   = et_q;
  assign gt   = gt_q;

endmodule

// File: tb/tb_seq_chunk_comparator.sv
// Scoreboard bench for seq_chunk_comparator: directed vectors, decoupled monitor.
// Covers the SEQ_CMP_SIGNED_EN path when that macro is defined.
module tb_seq_chunk_comparator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        l = 1'b0;
  logic        e = 1'b0;
  logic        g = 1'b0;
`ifdef SEQ_CMP_SIGNED_EN
  logic        sgn = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic        lt;
  logic        et;
  logic        gt;

  seq_chunk_comparator #(.WIDTH(16), .CHUNK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .l     (l),
    .e     (e),
    .g     (g),
`ifdef SEQ_CMP_SIGNED_EN
    .sgn   (sgn),
`endif
    .busy  (busy),
    .done  (done),
    .lt    (lt),
    .et    (et),
    .gt    (gt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] res;
    int         cyc;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t x;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cyc=%0d required none", cyc);
      end else begin
        x = sb.pop_front();
        if ({lt, et, gt} !== x.res || cyc != x.cyc) begin
          n_err++;
          $display("FAIL %s: got {lt,et,gt}=%b cyc=%0d required %b cyc=%0d",
                   x.nm, {lt, et, gt}, cyc, x.res, x.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Drives a one-cycle start; k = chunks expected to be examined.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] leg, input logic [2:0] res,
                       input int k, input string nm);
    @(negedge clk);
    A = a;
    B = b;
    {l, e, g} = leg;
    start = 1'b1;
    sb.push_back('{res, cyc + k + 1, nm});
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_c1"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got %0d pending results required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'({lt, et, gt}), 32'd0);
    reset = 1'b0;

    issue(16'h1234, 16'h1234, 3'b010, 3'b010, 4, "eq_1234");
    wait_idle();

    issue(16'h8000, 16'h7FFF, 3'b000, 3'b001, 1, "uns_8000");
    wait_idle();
`ifdef SEQ_CMP_SIGNED_EN
    sgn = 1'b1;
    issue(16'h8000, 16'h7FFF, 3'b000, 3'b100, 1, "sgn_8000");
    wait_idle();
    issue(16'hFFF0, 16'h0010, 3'b000, 3'b100, 1, "sgn_neg");
    wait_idle();
    sgn = 1'b0;
`endif

    issue(16'h12F4, 16'h12F5, 3'b000, 3'b100, 4, "lsb_lt");
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_res", 32'({lt, et, gt}), 32'b100);

    issue(16'hABCD, 16'hABCD, 3'b100, 3'b100, 4, "casc_l");
    wait_idle();
    issue(16'hABCD, 16'hABCD, 3'b001, 3'b001, 4, "casc_g");
    chk("hold_on_start", 32'({lt, et, gt}), 32'b100);
    wait_idle();
    issue(16'h0F0F, 16'h0F0F, 3'b111, 3'b111, 4, "casc_all");
    wait_idle();

    issue(16'h0001, 16'h0002, 3'b000, 3'b100, 4, "ignore_2nd");
    A = 16'hFFFF;
    B = 16'h0000;
    {l, e, g} = 3'b001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    issue(16'h1200, 16'h1300, 3'b000, 3'b100, 2, "mid_lt");
    wait_idle();
    issue(16'h5000, 16'h4FFF, 3'b000, 3'b001, 1, "top_gt");
    wait_idle();

    @(negedge clk);
    A = 16'h5555;
    B = 16'h5555;
    {l, e, g} = 3'b010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_res", 32'({lt, et, gt}), 32'd0);
    repeat (6) @(negedge clk);

    issue(16'h00F0, 16'h0F00, 3'b000, 3'b100, 2, "after_abort");
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish required finish by 100000");
    $fatal(1);
  end

endmodule
